// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for the 8-bit core: walks the ROM,
// resolves halt/branch/branchb itself, and guards runaway programs with a watchdog.
module fetch_sequencer #(
  parameter logic [7:0]  PROG0_BASE = 8'd0,
  parameter logic [7:0]  PROG1_BASE = 8'd93,
  parameter logic [7:0]  PROG2_BASE = 8'd139,
  parameter logic [15:0] MAX_INSTR  = 16'd4000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [1:0]  prog_sel_i,
  input  logic [7:0]  inst_i,
  input  logic        flag_i,
  input  logic [7:0]  offset_i,
  input  logic        stall_i,
  output logic [7:0]  address_o,
  output logic        inst_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_ERROR
  } state_t;

  state_t      state;
  logic [7:0]  pc;
  logic [15:0] count;
  logic        done_q;
  logic        err_q;

  logic        is_halt;
  logic        is_branch;
  logic        is_branchb;
  logic [7:0]  next_pc;
  logic [7:0]  base_addr;
  logic [15:0] count_inc;

  // Opcode decode and next-PC selection; all arithmetic wraps modulo 256.
  always_comb begin
    is_halt    = (inst_i == 8'b1000_1000);
    is_branch  = (inst_i[7:3] == 5'b11110);
    is_branchb = (inst_i[7:3] == 5'b10110);
    next_pc    = pc + 8'd1;
    if (is_branch && flag_i) begin
      next_pc = pc + 8'd1 + offset_i;
    end else if (is_branchb && flag_i) begin
      next_pc = pc - offset_i;
    end
    count_inc = (count == 16'hFFFF) ? count : count + 16'd1;
    case (prog_sel_i)
      2'd0:    base_addr = PROG0_BASE;
      2'd1:    base_addr = PROG1_BASE;
      default: base_addr = PROG2_BASE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state  <= ST_IDLE;
      pc     <= 8'd0;
      count  <= 16'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (!stall_i) begin
            count <= count_inc;
            // Halt wins over the watchdog when both land on the same retirement.
            if (is_halt) begin
              state  <= ST_HALTED;
              done_q <= 1'b1;
            end else begin
              pc <= next_pc;
              if (count_inc == MAX_INSTR) begin
                state <= ST_ERROR;
                err_q <= 1'b1;
              end
            end
          end
        end
        default: begin
          if (start_i) begin
            pc    <= base_addr;
            count <= 16'd0;
            err_q <= 1'b0;
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

  assign address_o     = pc;
  assign instr_count_o = count;
  assign busy_o        = (state == ST_RUN);
  assign inst_valid_o  = (state == ST_RUN) && !stall_i;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: branch arithmetic, stalls, halt/restart,
// watchdog on a small-limit instance, and asynchronous reset.
module tb_fetch_sequencer;

  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] HALT = 8'b1000_1000;
  localparam logic [7:0] BR   = 8'b1111_0111;
  localparam logic [7:0] BRB  = 8'b1011_0111;

  logic        clk_i;
  logic        reset_n_i;
  logic        start_i;
  logic        start_w;
  logic [1:0]  prog_sel_i;
  logic [7:0]  inst_i;
  logic        flag_i;
  logic [7:0]  offset_i;
  logic        stall_i;

  logic [7:0]  address_o,     w_address;
  logic        inst_valid_o,  w_inst_valid;
  logic        busy_o,        w_busy;
  logic        done_o,        w_done;
  logic        err_o,         w_err;
  logic [15:0] instr_count_o, w_count;

  int test_count = 0;
  int fail_count = 0;

  fetch_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .prog_sel_i(prog_sel_i),
    .inst_i(inst_i), .flag_i(flag_i), .offset_i(offset_i), .stall_i(stall_i),
    .address_o(address_o), .inst_valid_o(inst_valid_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .instr_count_o(instr_count_o)
  );

  fetch_sequencer #(.MAX_INSTR(16'd10)) dut_wd (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_w), .prog_sel_i(prog_sel_i),
    .inst_i(inst_i), .flag_i(flag_i), .offset_i(offset_i), .stall_i(stall_i),
    .address_o(w_address), .inst_valid_o(w_inst_valid), .busy_o(w_busy),
    .done_o(w_done), .err_o(w_err), .instr_count_o(w_count)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of datapath inputs and land 1ns after the next rising edge.
  task automatic apply_stimulus(input logic [7:0] inst, input logic flag,
                                input logic [7:0] offset, input logic stall);
    inst_i   = inst;
    flag_i   = flag;
    offset_i = offset;
    stall_i  = stall;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; start_w = 1'b0; prog_sel_i = 2'd0;
    inst_i = NOP; flag_i = 1'b0; offset_i = 8'd0; stall_i = 1'b0;
    #12;
    check_output("reset_addr", 16'(address_o), 16'd0);
    check_output("reset_count", instr_count_o, 16'd0);
    check_output("reset_flags", {12'd0, inst_valid_o, busy_o, done_o, err_o}, 16'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    start_i = 1'b1; prog_sel_i = 2'd1;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("start_addr", 16'(address_o), 16'd93);
    check_output("start_busy", 16'(busy_o), 16'd1);
    check_output("start_count", instr_count_o, 16'd0);

    prog_sel_i = 2'd2;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    start_i = 1'b0;
    check_output("start_ignored_in_run", 16'(address_o), 16'd94);

    apply_stimulus(BRB, 1'b1, 8'd77, 1'b0);
    check_output("brb_to_17", 16'(address_o), 16'd17);
    apply_stimulus(BR, 1'b1, 8'd6, 1'b0);
    check_output("br_taken", 16'(address_o), 16'd24);
    apply_stimulus(BRB, 1'b1, 8'd7, 1'b0);
    apply_stimulus(BR, 1'b0, 8'd6, 1'b0);
    check_output("br_not_taken", 16'(address_o), 16'd18);
    apply_stimulus(BR, 1'b1, 8'd107, 1'b0);
    check_output("br_to_126", 16'(address_o), 16'd126);
    apply_stimulus(BRB, 1'b1, 8'd24, 1'b0);
    check_output("brb_taken", 16'(address_o), 16'd102);
    apply_stimulus(BRB, 1'b1, 8'd97, 1'b0);
    apply_stimulus(BRB, 1'b1, 8'd130, 1'b0);
    check_output("brb_wrap", 16'(address_o), 16'd131);
    apply_stimulus(BRB, 1'b0, 8'd50, 1'b0);
    check_output("brb_not_taken", 16'(address_o), 16'd132);
    apply_stimulus(BRB, 1'b1, 8'd92, 1'b0);
    check_output("brb_to_40", 16'(address_o), 16'd40);
    check_output("count_before_stall", instr_count_o, 16'd11);

    inst_i = NOP; stall_i = 1'b1; #1;
    check_output("stall_valid", 16'(inst_valid_o), 16'd0);
    for (int i = 0; i < 3; i++) apply_stimulus(NOP, 1'b0, 8'd0, 1'b1);
    check_output("stall_addr", 16'(address_o), 16'd40);
    check_output("stall_count", instr_count_o, 16'd11);
    stall_i = 1'b0; #1;
    check_output("unstall_valid", 16'(inst_valid_o), 16'd1);
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("resume_addr", 16'(address_o), 16'd41);

    apply_stimulus(8'hFF, 1'b1, 8'd50, 1'b0);
    check_output("ff_is_plain", 16'(address_o), 16'd42);
    apply_stimulus(BR, 1'b1, 8'd212, 1'b0);
    check_output("br_to_255", 16'(address_o), 16'd255);
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("pc_wrap", 16'(address_o), 16'd0);
    check_output("count_15", instr_count_o, 16'd15);

    reset_n_i = 1'b0; #1;
    check_output("async_reset_addr", 16'(address_o), 16'd0);
    check_output("async_reset_count", instr_count_o, 16'd0);
    check_output("async_reset_flags", {12'd0, inst_valid_o, busy_o, done_o, err_o}, 16'd0);
    #2; reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    start_i = 1'b1; prog_sel_i = 2'd0;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    start_i = 1'b0;
    for (int i = 0; i < 92; i++) apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("pre_halt_addr", 16'(address_o), 16'd92);
    apply_stimulus(HALT, 1'b0, 8'd0, 1'b0);
    check_output("halt_count", instr_count_o, 16'd93);
    check_output("halt_done", 16'(done_o), 16'd1);
    check_output("halt_busy", 16'(busy_o), 16'd0);
    check_output("halt_addr", 16'(address_o), 16'd92);
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("done_one_cycle", 16'(done_o), 16'd0);
    check_output("halted_addr_held", 16'(address_o), 16'd92);
    check_output("halted_count_held", instr_count_o, 16'd93);
    start_i = 1'b1; prog_sel_i = 2'd2;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    start_i = 1'b0;
    check_output("restart_addr", 16'(address_o), 16'd139);
    check_output("restart_count", instr_count_o, 16'd0);
    apply_stimulus(HALT, 1'b0, 8'd0, 1'b0);

    start_w = 1'b1; prog_sel_i = 2'd0;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    start_w = 1'b0;
    check_output("wd_start_busy", 16'(w_busy), 16'd1);
    for (int i = 0; i < 9; i++) apply_stimulus((i % 2 == 0) ? NOP : BRB, 1'b1, 8'd1, 1'b0);
    check_output("wd_9_err", 16'(w_err), 16'd0);
    check_output("wd_9_addr", 16'(w_address), 16'd1);
    apply_stimulus(BRB, 1'b1, 8'd1, 1'b0);
    check_output("wd_trip_err", 16'(w_err), 16'd1);
    check_output("wd_trip_busy", 16'(w_busy), 16'd0);
    check_output("wd_trip_count", w_count, 16'd10);
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    check_output("wd_err_held", 16'(w_err), 16'd1);
    check_output("wd_no_done", 16'(w_done), 16'd0);
    start_w = 1'b1;
    apply_stimulus(NOP, 1'b0, 8'd0, 1'b0);
    start_w = 1'b0;
    check_output("wd_restart_err", 16'(w_err), 16'd0);
    check_output("wd_restart_count", w_count, 16'd0);
    for (int i = 0; i < 9; i++) apply_stimulus((i % 2 == 0) ? NOP : BRB, 1'b1, 8'd1, 1'b0);
    apply_stimulus(HALT, 1'b0, 8'd0, 1'b0);
    check_output("wd_halt_prio_done", 16'(w_done), 16'd1);
    check_output("wd_halt_prio_err", 16'(w_err), 16'd0);
    check_output("wd_halt_prio_count", w_count, 16'd10);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
